// File: rtl/xor_nn_ctrl_if.sv
// Config, request and response handshakes between a host and xor_nn_ctrl.
// The host side uses master and the controller uses slave.
interface xor_nn_ctrl_if #(
  parameter int BITS_PER_WORD = 8
);
  logic                     cfg_start;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [BITS_PER_WORD-1:0] cfg_data;
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    output req_valid, req_data, rsp_ready,
    input  cfg_ready, req_ready,
    input  rsp_valid, rsp_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    input  req_valid, req_data, rsp_ready,
    output cfg_ready, req_ready,
    output rsp_valid, rsp_data
  );
endinterface

// File: rtl/xor_nn_ctrl.sv
// xor_nn sequencer: weight loader and single-shot inference controller.
// XOR_NN_CTRL_CHECKSUM_EN adds a 10th load byte checked against the weight sum.
module xor_nn_ctrl #(
  parameter int NN_LATENCY    = 2,
  parameter int BITS_PER_WORD = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  xor_nn_ctrl_if.slave             bus,
  output logic                     loaded,
  output logic                     err,
  output logic                     nn_weights_en,
  output logic                     nn_weights_layer_address,
  output logic [1:0]               nn_weights_n_address,
  output logic [1:0]               nn_weights_m_address,
  output logic [BITS_PER_WORD-1:0] nn_weights_data,
  output logic                     nn_in_en,
  output logic [1:0]               nn_in_data,
  input  logic                     nn_out_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef XOR_NN_CTRL_CHECKSUM_EN
    CHECK,
`endif
    READY,
    ISSUE,
    WAIT,
    RESP,
    ERROR
  } state_t;

`ifdef XOR_NN_CTRL_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif

  state_t                   state;
  state_t                   next;
  logic [3:0]               idx;
  logic [3:0]               cnt;
  logic [BITS_PER_WORD-1:0] sum;
  logic                     cfg_fire;
  logic                     req_fire;
  logic                     restart;
  logic                     w_layer;
  logic [1:0]               w_n;
  logic [1:0]               w_m;

`ifdef XOR_NN_CTRL_CHECKSUM_EN
  logic [BITS_PER_WORD-1:0] chk;
  logic                     err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.cfg_ready = (state == LOAD);
  assign bus.req_ready = (state == READY) && !bus.cfg_start;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign restart       = bus.cfg_start &&
                         (state inside {IDLE, LOAD, READY, ERROR});

  // Layer 0 is 3x2 (m fastest), layer 1 is 3x1.
  always_comb begin
    w_layer = 1'b0;
    w_n     = idx[2:1];
    w_m     = {1'b0, idx[0]};
    if (idx >= 4'd6) begin
      w_layer = 1'b1;
      w_n     = 2'(idx - 4'd6);
      w_m     = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (restart) next = LOAD;
      LOAD: begin
        if (restart) next = LOAD;
        else if (cfg_fire && idx == LAST)
`ifdef XOR_NN_CTRL_CHECKSUM_EN
          next = CHECK;
`else
          next = READY;
`endif
      end
`ifdef XOR_NN_CTRL_CHECKSUM_EN
      CHECK: next = (chk == sum) ? READY : ERROR;
`endif
      READY: begin
        if (restart)       next = LOAD;
        else if (req_fire) next = ISSUE;
      end
      ISSUE: next = WAIT;
      WAIT:  if (cnt == 4'd1) next = RESP;
      RESP:  if (bus.rsp_ready) next = READY;
      ERROR: if (restart) next = LOAD;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx                      <= '0;
      cnt                      <= '0;
      sum                      <= '0;
      loaded                   <= 1'b0;
      nn_weights_en            <= 1'b0;
      nn_weights_layer_address <= 1'b0;
      nn_weights_n_address     <= '0;
      nn_weights_m_address     <= '0;
      nn_weights_data          <= '0;
      nn_in_en                 <= 1'b0;
      nn_in_data               <= '0;
      bus.rsp_valid            <= 1'b0;
      bus.rsp_data             <= 1'b0;
`ifdef XOR_NN_CTRL_CHECKSUM_EN
      chk                      <= '0;
      err_q                    <= 1'b0;
`endif
    end else begin
      nn_weights_en <= 1'b0;
      nn_in_en      <= 1'b0;
      nn_in_data    <= '0;
      if (restart) begin
        idx    <= '0;
        sum    <= '0;
        loaded <= 1'b0;
`ifdef XOR_NN_CTRL_CHECKSUM_EN
        err_q  <= 1'b0;
`endif
      end else if (cfg_fire) begin
        idx <= idx + 4'd1;
        if (idx < 4'd9) begin
          nn_weights_en            <= 1'b1;
          nn_weights_layer_address <= w_layer;
          nn_weights_n_address     <= w_n;
          nn_weights_m_address     <= w_m;
          nn_weights_data          <= bus.cfg_data;
          sum                      <= sum + bus.cfg_data;
        end
`ifdef XOR_NN_CTRL_CHECKSUM_EN
        else chk <= bus.cfg_data;
`else
        if (idx == LAST) loaded <= 1'b1;
`endif
      end
`ifdef XOR_NN_CTRL_CHECKSUM_EN
      if (state == CHECK) begin
        loaded <= (chk == sum);
        err_q  <= (chk != sum);
      end
`endif
      if (req_fire) begin
        nn_in_en   <= 1'b1;
        nn_in_data <= bus.req_data;
      end
      if (state == ISSUE) cnt <= 4'(NN_LATENCY);
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          bus.rsp_data  <= nn_out_data;
          bus.rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_nn_ctrl.sv
// Self-checking bench for xor_nn_ctrl: weight load order, inference timing,
// handshake stalls, restart priority, optional checksum and async reset.
module tb_xor_nn_ctrl;
  localparam int L   = 2;
  localparam int BPW = 8;
`ifdef XOR_NN_CTRL_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NB = CK ? 10 : 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  xor_nn_ctrl_if #(.BITS_PER_WORD(BPW)) bus ();

  logic           loaded, err, wen, wl, in_en, out_data;
  logic [1:0]     wn, wm, in_data;
  logic [BPW-1:0] wd;

  xor_nn_ctrl #(.NN_LATENCY(L), .BITS_PER_WORD(BPW)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .bus                      (bus),
    .loaded                   (loaded),
    .err                      (err),
    .nn_weights_en            (wen),
    .nn_weights_layer_address (wl),
    .nn_weights_n_address     (wn),
    .nn_weights_m_address     (wm),
    .nn_weights_data          (wd),
    .nn_in_en                 (in_en),
    .nn_in_data               (in_data),
    .nn_out_data              (out_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  bit exp_q[$];

  logic [7:0] wts[9] = '{8'hF6, 8'h01, 8'h01, 8'h00, 8'h01,
                         8'h01, 8'h00, 8'h01, 8'hFE};
  logic       tl[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic [1:0] tn[9] = '{0, 0, 1, 1, 2, 2, 0, 1, 2};
  logic [1:0] tm[9] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};

  // Datapath model: XOR result valid only in the cycle L after nn_in_en.
  int   dp_cnt = 0;
  logic dp_val = 1'b0;
  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (in_en) begin
      dp_cnt <= 1;
      dp_val <= ^in_data;
    end else if (dp_cnt != 0 && dp_cnt < 15) begin
      dp_cnt <= dp_cnt + 1;
    end
  end
  assign out_data = (dp_cnt == 0) ? 1'b0 :
                    (dp_cnt == L) ? dp_val : ~dp_val;

  function automatic logic [22:0] outv();
    return {bus.cfg_ready, bus.req_ready, bus.rsp_valid, bus.rsp_data,
            loaded, err, wen, wl, wn, wm, wd, in_en, in_data};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (outv() !== 23'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", outv());
    end
    reset_n = 1'b1;
    cyc();
    checks++;
    if ({bus.cfg_ready, bus.req_ready, loaded} !== 3'b000) begin
      failures++;
      $display("FAIL idle_readies: got %b want 000",
               {bus.cfg_ready, bus.req_ready, loaded});
    end
  endtask

  task automatic test_load(input bit do_start, input int delta,
                           input bit ok);
    logic [7:0] csum;
    csum = 8'hF9 + 8'(delta);
    if (do_start) begin
      bus.cfg_start = 1'b1;
      cyc();
      bus.cfg_start = 1'b0;
      checks++;
      if ({bus.cfg_ready, loaded, err} !== 3'b100) begin
        failures++;
        $display("FAIL load_start: got %b want 100",
                 {bus.cfg_ready, loaded, err});
      end
    end
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < NB; i++) begin
      bus.cfg_data = (i < 9) ? wts[i] : csum;
      cyc();
      checks++;
      if (i < 9) begin
        if ({wen, wl, wn, wm, wd} !== {1'b1, tl[i], tn[i], tm[i], wts[i]}) begin
          failures++;
          $display("FAIL weight_write %0d: got %h want %h", i,
                   {wen, wl, wn, wm, wd},
                   {1'b1, tl[i], tn[i], tm[i], wts[i]});
        end
      end else if (wen !== 1'b0) begin
        failures++;
        $display("FAIL checksum_not_written: got %b want 0", wen);
      end
      if (i == 0) begin
        checks++;
        if (loaded !== 1'b0) begin
          failures++;
          $display("FAIL loaded_during_load: got %b want 0", loaded);
        end
      end
    end
    bus.cfg_valid = 1'b0;
    cyc();
    checks++;
    if ({wen, loaded, err} !== {1'b0, ok, CK && !ok}) begin
      failures++;
      $display("FAIL load_done: got %b want %b", {wen, loaded, err},
               {1'b0, ok, CK && !ok});
    end
  endtask

  task automatic test_infer(input logic [1:0] x, input int hold);
    int   n;
    logic d;
    bit   e;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_pre: got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_data  = x;
    exp_q.push_back(^x);
    cyc();
    bus.req_valid = 1'b0;
    checks++;
    if ({in_en, in_data} !== {1'b1, x}) begin
      failures++;
      $display("FAIL issue: got %b want %b", {in_en, in_data}, {1'b1, x});
    end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (n != L + 1) begin
      failures++;
      $display("FAIL rsp_latency: got %0d want %0d", n, L + 1);
    end
    d = bus.rsp_data;
    for (int h = 0; h < hold; h++) begin
      cyc();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.req_ready} !== {1'b1, d, 1'b0}) begin
        failures++;
        $display("FAIL rsp_hold %0d: got %b want %b", h,
                 {bus.rsp_valid, bus.rsp_data, bus.req_ready},
                 {1'b1, d, 1'b0});
      end
    end
    bus.rsp_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    checks++;
    if (bus.rsp_data !== e) begin
      failures++;
      $display("FAIL rsp_data x=%b: got %b want %b", x, bus.rsp_data, e);
    end
    cyc();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rsp_release: got %b want 01",
               {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int t;
    int t_prev;
    bit e;
    t_prev = 0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_data = 2'(k);
      n = 0;
      while (!bus.req_ready && n < 30) begin
        cyc();
        n++;
      end
      t = cyc_no;
      if (k > 0) begin
        checks++;
        if (t - t_prev != L + 3) begin
          failures++;
          $display("FAIL b2b_spacing %0d: got %0d want %0d", k,
                   t - t_prev, L + 3);
        end
      end
      t_prev = t;
      exp_q.push_back(^bus.req_data);
      cyc();
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        cyc();
        n++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e) begin
        failures++;
        $display("FAIL b2b_rsp %0d: got %b%b want 1%b", k,
                 bus.rsp_valid, bus.rsp_data, e);
      end
    end
    bus.req_valid = 1'b0;
    cyc();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_start_vs_req();
    bus.cfg_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_blocks_req: got %b want 0", bus.req_ready);
    end
    cyc();
    bus.cfg_start = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.cfg_ready, loaded, in_en} !== 3'b100) begin
      failures++;
      $display("FAIL start_wins: got %b want 100",
               {bus.cfg_ready, loaded, in_en});
    end
    test_load(1'b0, 0, 1'b1);
  endtask

  task automatic test_restart_mid_load();
    bus.cfg_start = 1'b1;
    cyc();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cfg_data = wts[i];
      cyc();
    end
    bus.cfg_start = 1'b1;
    bus.cfg_data  = 8'h55;
    cyc();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    checks++;
    if ({wen, loaded, bus.cfg_ready} !== 3'b001) begin
      failures++;
      $display("FAIL restart_discard: got %b want 001",
               {wen, loaded, bus.cfg_ready});
    end
    test_load(1'b0, 0, 1'b1);
  endtask

`ifdef XOR_NN_CTRL_CHECKSUM_EN
  task automatic test_checksum_err();
    test_load(1'b1, 1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_data  = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL err_req_ready: got %b want 0", bus.req_ready);
    end
    cyc();
    bus.req_valid = 1'b0;
    checks++;
    if ({in_en, err, loaded} !== 3'b010) begin
      failures++;
      $display("FAIL err_hold: got %b want 010", {in_en, err, loaded});
    end
    test_load(1'b1, 0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid_wait();
    bus.req_valid = 1'b1;
    bus.req_data  = 2'b10;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outv() !== 23'h0) begin
      failures++;
      $display("FAIL async_reset: got %h want 0", outv());
    end
    exp_q.delete();
    cyc();
    reset_n = 1'b1;
    cyc();
    bus.req_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.cfg_ready, loaded} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 000",
               {bus.req_ready, bus.cfg_ready, loaded});
    end
    cyc();
    bus.req_valid = 1'b0;
    checks++;
    if (in_en !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_no_issue: got %b want 0", in_en);
    end
    test_load(1'b1, 0, 1'b1);
    test_infer(2'b10, 0);
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_load(1'b1, 0, 1'b1);
    test_infer(2'b01, 0);
    test_infer(2'b11, 5);
    test_infer(2'b00, 0);
    test_back_to_back();
    test_start_vs_req();
    test_restart_mid_load();
`ifdef XOR_NN_CTRL_CHECKSUM_EN
    test_checksum_err();
`endif
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
